// File: rtl/mem_arbiter.sv
// Shares one TLB port and one physical bus between instruction fetch and data
// access, with round-robin arbitration, bus timeout and pipeline-flush handling.
module mem_arbiter #(
    parameter int unsigned BUS_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    output logic        if_tlbl,

    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_sel,
    output logic [31:0] mem_rdata,
    output logic        mem_ack,
    output logic        mem_tlbm,
    output logic        mem_tlbl,
    output logic        mem_tlbs,

    output logic [31:0] mmu_addr,
    output logic        mmu_write,
    output logic        tlb_ce,
    input  logic [31:0] tlb_addr,
    input  logic        excepttype_is_tlbm,
    input  logic        excepttype_is_tlbl,
    input  logic        excepttype_is_tlbs,

    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_sel,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,

    input  logic        flush,
    output logic        bus_err,
    output logic        stallreq_if,
    output logic        stallreq_mem
);

    localparam int unsigned   CW       = (BUS_TIMEOUT > 2) ? $clog2(BUS_TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(BUS_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, BUS, RESP, DRAIN} state_t;

    state_t        state_q, state_d;
    logic          last_data_q, last_data_d;   // 1: most recent grant went to the data side
    logic          side_data_q, side_data_d;   // side currently being served
    logic [CW-1:0] cnt_q, cnt_d;
    logic          bus_req_q, bus_req_d;
    logic          bus_we_q, bus_we_d;
    logic [31:0]   bus_addr_q, bus_addr_d;
    logic [31:0]   bus_wdata_q, bus_wdata_d;
    logic [3:0]    bus_sel_q, bus_sel_d;
    logic [31:0]   if_rdata_q, if_rdata_d;
    logic [31:0]   mem_rdata_q, mem_rdata_d;
    logic          if_tlbl_q, if_tlbl_d;
    logic          tlbm_q, tlbm_d;
    logic          tlbl_q, tlbl_d;
    logic          tlbs_q, tlbs_d;
    logic          err_q, err_d;

    logic          grant;
    logic          grant_data;
    logic          exc_any;
    logic          timeout;
    logic          resp_live;

    always_comb begin
        state_d     = state_q;
        last_data_d = last_data_q;
        side_data_d = side_data_q;
        cnt_d       = cnt_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_sel_d   = bus_sel_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        if_tlbl_d   = if_tlbl_q;
        tlbm_d      = tlbm_q;
        tlbl_d      = tlbl_q;
        tlbs_d      = tlbs_q;
        err_d       = err_q;
        tlb_ce      = 1'b0;
        mmu_addr    = '0;
        mmu_write   = 1'b0;
        grant       = 1'b0;
        exc_any     = excepttype_is_tlbm | excepttype_is_tlbl | excepttype_is_tlbs;
        // On contention the side that did not win last time gets the grant
        grant_data  = mem_req & (~if_req | ~last_data_q);
        timeout     = (cnt_q == CNT_LAST);

        unique case (state_q)
            IDLE: begin
                grant = ~flush & (if_req | mem_req);
                if (grant) begin
                    tlb_ce      = 1'b1;
                    mmu_addr    = grant_data ? mem_addr : if_addr;
                    mmu_write   = grant_data & mem_we;
                    last_data_d = grant_data;
                    side_data_d = grant_data;
                    if (exc_any) begin
                        state_d   = RESP;
                        err_d     = 1'b0;
                        if_tlbl_d = ~grant_data & excepttype_is_tlbl;
                        tlbm_d    = grant_data & excepttype_is_tlbm;
                        tlbl_d    = grant_data & excepttype_is_tlbl;
                        tlbs_d    = grant_data & excepttype_is_tlbs;
                        if (grant_data) mem_rdata_d = '0;
                        else            if_rdata_d  = '0;
                    end else begin
                        state_d     = BUS;
                        cnt_d       = '0;
                        bus_req_d   = 1'b1;
                        bus_addr_d  = tlb_addr;
                        bus_we_d    = grant_data & mem_we;
                        bus_wdata_d = grant_data ? mem_wdata : '0;
                        bus_sel_d   = grant_data ? mem_sel : 4'hF;
                    end
                end
            end
            BUS: begin
                if (bus_ack) begin
                    bus_req_d = 1'b0;
                    if (flush) begin
                        state_d = IDLE;
                    end else begin
                        state_d   = RESP;
                        err_d     = 1'b0;
                        if_tlbl_d = 1'b0;
                        tlbm_d    = 1'b0;
                        tlbl_d    = 1'b0;
                        tlbs_d    = 1'b0;
                        if (side_data_q) mem_rdata_d = bus_rdata;
                        else             if_rdata_d  = bus_rdata;
                    end
                end else if (flush) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end else if (timeout) begin
                    bus_req_d = 1'b0;
                    state_d   = RESP;
                    err_d     = 1'b1;
                    if_tlbl_d = 1'b0;
                    tlbm_d    = 1'b0;
                    tlbl_d    = 1'b0;
                    tlbs_d    = 1'b0;
                    if (side_data_q) mem_rdata_d = '0;
                    else             if_rdata_d  = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DRAIN: begin
                if (bus_ack | timeout) begin
                    bus_req_d = 1'b0;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            last_data_q <= 1'b0;
            side_data_q <= 1'b0;
            cnt_q       <= '0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_sel_q   <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
            if_tlbl_q   <= 1'b0;
            tlbm_q      <= 1'b0;
            tlbl_q      <= 1'b0;
            tlbs_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_data_q <= last_data_d;
            side_data_q <= side_data_d;
            cnt_q       <= cnt_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_sel_q   <= bus_sel_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
            if_tlbl_q   <= if_tlbl_d;
            tlbm_q      <= tlbm_d;
            tlbl_q      <= tlbl_d;
            tlbs_q      <= tlbs_d;
            err_q       <= err_d;
        end
    end

    // Response pulses are gated by flush in the same cycle so a flushed RESP is silent
    assign resp_live    = (state_q == RESP) & ~flush;
    assign if_ack       = resp_live & ~side_data_q;
    assign mem_ack      = resp_live & side_data_q;
    assign if_tlbl      = resp_live & if_tlbl_q;
    assign mem_tlbm     = resp_live & tlbm_q;
    assign mem_tlbl     = resp_live & tlbl_q;
    assign mem_tlbs     = resp_live & tlbs_q;
    assign bus_err      = resp_live & err_q;
    assign if_rdata     = if_rdata_q;
    assign mem_rdata    = mem_rdata_q;

    assign bus_req      = bus_req_q;
    assign bus_we       = bus_we_q;
    assign bus_addr     = bus_addr_q;
    assign bus_wdata    = bus_wdata_q;
    assign bus_sel      = bus_sel_q;

    assign stallreq_if  = if_req & ~if_ack;
    assign stallreq_mem = mem_req & ~mem_ack;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a transaction-level model predicts grants,
// bus cycles and responses; an independent monitor compares the DUT outputs.
module tb_mem_arbiter;
    localparam int BT    = 4;
    localparam int NEVER = 1000;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, mem_req, mem_we, bus_ack, flush;
    logic [31:0] if_addr, mem_addr, mem_wdata, bus_rdata;
    logic [3:0]  mem_sel;
    logic        exc_m, exc_l, exc_s;
    logic [31:0] if_rdata, mem_rdata, mmu_addr, tlb_addr, bus_addr, bus_wdata;
    logic        if_ack, if_tlbl, mem_ack, mem_tlbm, mem_tlbl, mem_tlbs;
    logic        mmu_write, tlb_ce, bus_req, bus_we, bus_err, stallreq_if, stallreq_mem;
    logic [3:0]  bus_sel;

    always #5 clk = ~clk;

    // Bench TLB: unmapped-segment style translation, strips the top three bits
    assign tlb_addr = {3'b000, mmu_addr[28:0]};

    mem_arbiter #(.BUS_TIMEOUT(BT)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack), .if_tlbl(if_tlbl),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_sel(mem_sel), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mem_tlbm(mem_tlbm),
        .mem_tlbl(mem_tlbl), .mem_tlbs(mem_tlbs),
        .mmu_addr(mmu_addr), .mmu_write(mmu_write), .tlb_ce(tlb_ce), .tlb_addr(tlb_addr),
        .excepttype_is_tlbm(exc_m), .excepttype_is_tlbl(exc_l), .excepttype_is_tlbs(exc_s),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_sel(bus_sel), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
        .flush(flush), .bus_err(bus_err), .stallreq_if(stallreq_if), .stallreq_mem(stallreq_mem)
    );

    typedef struct {
        logic        side;    // 1: data
        logic [31:0] rdata;
        logic [3:0]  flags;   // {if_tlbl, mem_tlbm, mem_tlbl, mem_tlbs}
        logic        err;
    } resp_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  sel;
        int          len;
    } bus_t;

    resp_t exp_q[$];
    bus_t  bus_q[$];
    int    checks = 0;
    int    errors = 0;
    logic  last_data = 1'b0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    initial begin : monitor
        resp_t r;
        bus_t  cur;
        logic  prev_req;
        int    len;
        prev_req = 1'b0;
        len      = 0;
        cur      = '{32'h0, 1'b0, 32'h0, 4'h0, 0};
        forever begin
            @(negedge clk);
            #1;
            if (if_ack || mem_ack) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_ack", 32'({if_ack, mem_ack}), 32'h0);
                end else begin
                    r = exp_q.pop_front();
                    chk("ack_side", 32'({if_ack, mem_ack}), 32'({~r.side, r.side}));
                    chk("rdata", r.side ? mem_rdata : if_rdata, r.rdata);
                    chk("exc_flags", 32'({if_tlbl, mem_tlbm, mem_tlbl, mem_tlbs}), 32'(r.flags));
                    chk("bus_err", 32'(bus_err), 32'(r.err));
                end
            end else begin
                chk("quiet_flags", 32'({bus_err, if_tlbl, mem_tlbm, mem_tlbl, mem_tlbs}), 32'h0);
            end
            if (bus_req && !prev_req) begin
                len = 0;
                if (bus_q.size() == 0) begin
                    chk("unexpected_bus_req", 32'(bus_req), 32'h0);
                    cur = '{32'h0, 1'b0, 32'h0, 4'h0, 0};
                end else begin
                    cur = bus_q.pop_front();
                end
            end
            if (bus_req) begin
                len++;
                chk("bus_addr", bus_addr, cur.addr);
                chk("bus_we", 32'(bus_we), 32'(cur.we));
                chk("bus_wdata", bus_wdata, cur.wdata);
                chk("bus_sel", 32'(bus_sel), 32'(cur.sel));
            end
            if (!bus_req && prev_req) chk("bus_req_cycles", 32'(len), 32'(cur.len));
            prev_req = bus_req;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation still running, required to finish");
        $fatal(1, "watchdog expired");
    end

    // One arbitrated transaction. lat/fk are the BUS-relative cycle of bus_ack and flush.
    task automatic txn(input logic ir, input logic mr, input logic [31:0] ia, input logic [31:0] ma,
                       input logic we, input logic [31:0] wd, input logic [3:0] sel,
                       input logic [2:0] exc, input int lat, input int fk,
                       input logic fl_idle, input logic fl_resp, input logic [31:0] rd);
        logic        gd;
        logic [31:0] ga;
        int          len;
        logic        has_resp;
        resp_t       r;
        @(negedge clk);
        if_req = ir; mem_req = mr; if_addr = ia; mem_addr = ma;
        mem_we = we; mem_wdata = wd; mem_sel = sel; bus_ack = 1'b0; flush = 1'b0;
        if (fl_idle) begin
            flush = 1'b1;
            #1 chk("flush_idle_tlb_ce", 32'(tlb_ce), 32'h0);
            @(negedge clk);
            flush = 1'b0;
        end
        {exc_m, exc_l, exc_s} = exc;
        gd        = mr && (!ir || !last_data);
        last_data = gd;
        ga        = gd ? ma : ia;
        #1;
        chk("grant_tlb_ce", 32'(tlb_ce), 32'h1);
        chk("mmu_addr", mmu_addr, ga);
        chk("mmu_write", 32'(mmu_write), 32'(gd & we));
        chk("stallreq_if", 32'(stallreq_if), 32'(ir));
        chk("stallreq_mem", 32'(stallreq_mem), 32'(mr));
        @(negedge clk);
        if_req = 1'b0; mem_req = 1'b0; {exc_m, exc_l, exc_s} = 3'b000;
        r.side = gd;
        if (exc != 3'b000) begin
            r.rdata = 32'h0;
            r.err   = 1'b0;
            r.flags = gd ? {1'b0, exc} : {exc[1], 3'b000};
            if (fl_resp) flush = 1'b1;
            else         exp_q.push_back(r);
            @(negedge clk);
            flush = 1'b0;
        end else begin
            r.flags = 4'h0;
            if (lat < BT && lat <= fk) begin
                len = lat + 1; has_resp = (fk != lat); r.rdata = rd; r.err = 1'b0;
            end else if (fk < BT) begin
                len = ((lat < fk + BT) ? lat : fk + BT) + 1; has_resp = 1'b0;
                r.rdata = 32'h0; r.err = 1'b0;
            end else begin
                len = BT; has_resp = 1'b1; r.rdata = 32'h0; r.err = 1'b1;
            end
            bus_q.push_back('{{3'b000, ga[28:0]}, gd & we, gd ? wd : 32'h0, gd ? sel : 4'hF, len});
            for (int k = 0; k < len; k++) begin
                if (k > 0) @(negedge clk);
                bus_ack   = (k == lat);
                flush     = (k == fk);
                bus_rdata = (k == lat) ? rd : $urandom;
                if (k == len - 1 && has_resp && !fl_resp) exp_q.push_back(r);
                #1 chk("busy_tlb_ce", 32'(tlb_ce), 32'h0);
            end
            @(negedge clk);
            bus_ack = 1'b0;
            flush   = has_resp & fl_resp;
            if (has_resp) begin
                @(negedge clk);
                flush = 1'b0;
            end
        end
    endtask

    task automatic mid_reset(input int at_k);
        logic [31:0] ga;
        @(negedge clk);
        ga = $urandom;
        if_req = 1'b1; mem_req = 1'b0; if_addr = ga; flush = 1'b0; bus_ack = 1'b0;
        last_data = 1'b0;
        @(negedge clk);
        if_req = 1'b0;
        bus_q.push_back('{{3'b000, ga[28:0]}, 1'b0, 32'h0, 4'hF, at_k + 1});
        for (int k = 0; k <= at_k; k++) begin
            if (k > 0) @(negedge clk);
            if (k == at_k) rst = 1'b0;
        end
        @(negedge clk);
        rst = 1'b1;
        #1 chk("bus_req_after_reset", 32'(bus_req), 32'h0);
    endtask

    initial begin : driver
        int p, lat, fk;
        rst = 1'b0; if_req = 1'b0; mem_req = 1'b0; mem_we = 1'b0; bus_ack = 1'b0; flush = 1'b0;
        if_addr = 32'h0; mem_addr = 32'h0; mem_wdata = 32'h0; mem_sel = 4'h0; bus_rdata = 32'h0;
        exc_m = 1'b0; exc_l = 1'b0; exc_s = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_bus_req", 32'(bus_req), 32'h0);
        chk("rst_bus_we", 32'(bus_we), 32'h0);
        chk("rst_bus_addr", bus_addr, 32'h0);
        chk("rst_bus_wdata", bus_wdata, 32'h0);
        chk("rst_bus_sel", 32'(bus_sel), 32'h0);
        chk("rst_if_rdata", if_rdata, 32'h0);
        chk("rst_mem_rdata", mem_rdata, 32'h0);
        chk("rst_acks", 32'({if_ack, mem_ack, bus_err}), 32'h0);
        chk("rst_tlb_ce", 32'({tlb_ce, mmu_write}), 32'h0);
        chk("rst_mmu_addr", mmu_addr, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        last_data = 1'b0;

        // Contention straight after reset: data, fetch, data
        repeat (3) txn(1, 1, 32'h80000100, 32'h80002000, 0, 32'h0, 4'hF, 3'b000, 0, NEVER, 0, 0, $urandom);
        // Fetch-only read through the TLB
        txn(1, 0, 32'h80001000, 32'h0, 0, 32'h0, 4'h0, 3'b000, 2, NEVER, 0, 0, 32'h24020005);
        // Store with TLB store exception: no bus cycle
        txn(0, 1, 32'h0, 32'h00400010, 1, 32'hDEADBEEF, 4'h3, 3'b001, 0, NEVER, 0, 0, 32'h0);
        // Flush in second BUS cycle, ack three cycles later
        txn(1, 0, 32'hBFC00000, 32'h0, 0, 32'h0, 4'h0, 3'b000, 4, 1, 0, 0, 32'h12345678);
        // No ack at all: timeout with bus_err
        txn(0, 1, 32'h0, 32'hA0000040, 0, 32'h0, 4'hF, 3'b000, NEVER, NEVER, 0, 0, 32'h0);
        // Flush and ack together, flush in IDLE, flush in RESP, drain timeout
        txn(1, 0, 32'h80000200, 32'h0, 0, 32'h0, 4'h0, 3'b000, 1, 1, 0, 0, 32'h11111111);
        txn(0, 1, 32'h0, 32'h80000300, 1, 32'hCAFEF00D, 4'hC, 3'b000, 0, NEVER, 1, 0, 32'h0);
        txn(1, 1, 32'h80000400, 32'h80000500, 0, 32'h0, 4'hF, 3'b000, 1, NEVER, 0, 1, 32'h22222222);
        txn(1, 0, 32'h80000600, 32'h0, 0, 32'h0, 4'h0, 3'b010, 0, NEVER, 0, 1, 32'h0);
        txn(0, 1, 32'h0, 32'h80000700, 0, 32'h0, 4'hF, 3'b000, NEVER, 0, 0, 0, 32'h0);
        mid_reset(2);
        txn(1, 1, 32'h80000800, 32'h80000900, 0, 32'h0, 4'hF, 3'b110, 0, NEVER, 0, 0, 32'h0);

        for (int n = 0; n < 250; n++) begin
            p   = int'($urandom_range(0, 2));
            lat = int'($urandom_range(0, 6));
            fk  = ($urandom_range(0, 9) < 3) ? int'($urandom_range(0, 5)) : NEVER;
            txn(p != 1, p != 0, $urandom, $urandom, 1'($urandom), $urandom, 4'($urandom),
                ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000, lat, fk,
                $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0, $urandom);
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        chk("resp_queue_drained", 32'(exp_q.size()), 32'h0);
        chk("bus_queue_drained", 32'(bus_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
